// File: rtl/pixel_fetch_unpacker.sv
// Fetches packed RGB444 words from frame-buffer BRAM and unpacks them into one 12-bit pixel per handshake.
// Optional PIXEL_FETCH_STATS_EN adds a saturating underflow cycle counter output.
module pixel_fetch_unpacker #(
  parameter int ADDR_W     = 17,
  parameter int FB_WORDS   = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_en_fetching,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [31:0]       i_mem_data,
  output logic [11:0]       o_pix_data,
  output logic              o_pix_rts,
  input  logic              i_pix_rtr,
  output logic              o_underflow
`ifdef PIXEL_FETCH_STATS_EN
  ,
  output logic [15:0]       o_underflow_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_addr;
  logic [RD_LAT-1:0] r_vld;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_fcnt;
  logic [43:0]       r_stg;
  logic [5:0]        r_cnt;
  logic              r_underflow;

  logic [CW-1:0]     w_inflight;
  logic [CW:0]       w_used;
  logic              w_rd;
  logic              w_ret;
  logic              w_wr;
  logic              w_pop;
  logic              w_load;
  logic              w_under;
  logic [5:0]        w_keep;
  logic [31:0]       w_word;
  logic [43:0]       w_stg_next;
  logic [5:0]        w_cnt_next;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  // Credits cover both queued and in-flight words, so the FIFO cannot overflow.
  assign w_used = {1'b0, r_fcnt} + {1'b0, w_inflight};
  assign w_rd   = !i_rst && !i_frame_start && i_en_fetching && (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_ret  = r_vld[RD_LAT-1];
  assign w_wr   = w_ret && !i_frame_start;

  assign o_pix_rts  = (r_cnt >= 6'd12);
  assign o_pix_data = o_pix_rts ? r_stg[11:0] : 12'h000;
  assign o_mem_addr = r_addr;
  assign o_mem_rd   = w_rd;
  assign o_underflow = r_underflow;

  assign w_pop   = o_pix_rts && i_pix_rtr;
  assign w_under = i_pix_rtr && !o_pix_rts;
  assign w_keep  = r_cnt - (w_pop ? 6'd12 : 6'd0);
  assign w_load  = (r_fcnt != '0) && (w_keep < 6'd12);
  assign w_word  = r_mem[r_rp];

  assign w_stg_next = (r_stg >> (w_pop ? 6'd12 : 6'd0)) |
                      (w_load ? ({12'd0, w_word} << w_keep) : '0);
  assign w_cnt_next = w_keep + (w_load ? 6'd32 : 6'd0);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= i_mem_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_vld       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_fcnt      <= '0;
      r_stg       <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else if (i_frame_start) begin
      r_addr      <= '0;
      r_vld       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_fcnt      <= '0;
      r_stg       <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_rd) begin
        r_addr <= (r_addr == ADDR_W'(FB_WORDS - 1)) ? '0 : r_addr + 1'b1;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_vld[0] <= w_rd;
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_load) begin
        r_rp <= r_rp + 1'b1;
      end
      r_fcnt <= r_fcnt + CW'(w_wr) - CW'(w_load);
      r_stg  <= w_stg_next;
      r_cnt  <= w_cnt_next;
      if (w_under) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef PIXEL_FETCH_STATS_EN
  logic [15:0] r_ucnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ucnt <= '0;
    end else if (i_frame_start) begin
      r_ucnt <= '0;
    end else if (w_under && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end

  assign o_underflow_cnt = r_ucnt;
`endif

endmodule

// File: tb/tb_pixel_fetch_unpacker.sv
// Directed bench for pixel_fetch_unpacker: a BRAM model feeds words, and a scoreboard predicts the pixel stream.
module tb_pixel_fetch_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        en;
  logic        rtr;
  logic [16:0] addr;
  logic        rd;
  logic [31:0] mdata = '0;
  logic [11:0] pix;
  logic        rts;
  logic        uf;
`ifdef PIXEL_FETCH_STATS_EN
  logic [15:0] ucnt;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [11:0]  expq[$];
  logic [127:0] acc = '0;
  int           nb  = 0;

  always #5 clk = ~clk;

  pixel_fetch_unpacker #(
    .ADDR_W(17), .FB_WORDS(115200), .FIFO_DEPTH(8), .RD_LAT(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_en_fetching(en),
    .o_mem_addr(addr), .o_mem_rd(rd), .i_mem_data(mdata),
    .o_pix_data(pix), .o_pix_rts(rts), .i_pix_rtr(rtr), .o_underflow(uf)
`ifdef PIXEL_FETCH_STATS_EN
    , .o_underflow_cnt(ucnt)
`endif
  );

  function automatic logic [31:0] word_of(input logic [16:0] a);
    case (a)
      17'd0:   return 32'h76543210;
      17'd1:   return 32'hFEDCBA98;
      17'd2:   return 32'h10FEDCBA;
      default: return {a[15:0] ^ 16'hC35A, a[15:0] + 16'h1234};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rd) mdata <= word_of(addr);
  end

  // Scoreboard: words are unpacked into expected pixels when their read is issued.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      acc = '0;
      nb  = 0;
    end else begin
      if (rts && rtr) begin
        pops++;
        chk("sb_nonempty", (expq.size() != 0), 1);
        if (expq.size() != 0) chk("pix_data", pix, expq.pop_front());
      end
      if (rd) begin
        acc = acc | ({96'd0, word_of(addr)} << nb);
        nb  = nb + 32;
        while (nb >= 12) begin
          expq.push_back(acc[11:0]);
          acc = acc >> 12;
          nb  = nb - 12;
        end
      end
      if (fs) begin
        expq.delete();
        acc = '0;
        nb  = 0;
      end
    end
  end

  task automatic pulse_fs();
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
  endtask

  task automatic wait_rts(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rts && n < 50);
    chk(tag, rts, 1);
  endtask

  task automatic stream(input string tag, input int cycles);
    int p0;
    p0 = pops;
    @(posedge clk); #1 rtr = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rtr = 1'b0;
    chk(tag, pops - p0, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    logic [16:0] exp3 [3];
    exp3 = '{17'd115198, 17'd115199, 17'd0};

    rst = 1'b1; fs = 1'b0; en = 1'b0; rtr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {addr, rd, pix, rts, uf}, 32'd0);
    rst = 1'b0;

    // 1: three packed words streamed with the consumer ready
    en = 1'b1;
    pulse_fs();
    wait_rts("t1_rts", n);
    chk("t1_latency", n, 4);
    stream("t1_8_pixels", 8);
    chk("t1_no_underflow", uf, 0);

    // 2: consumer stalled, credits must stop reads and hold the pixel
    pulse_fs();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t2_rd_stopped", rd, 0);
    chk("t2_rts_held", rts, 1);
    chk("t2_pix_held", pix, 12'h210);
    stream("t2_gapfree", 24);
    chk("t2_no_underflow", uf, 0);

    // 3: address wrap at the end of the frame buffer
    en = 1'b0;
    pulse_fs();
    force dut.r_addr = 17'd115198;
    @(posedge clk); #1 release dut.r_addr;
    @(posedge clk); #1 en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_rd", rd, 1);
      chk("t3_addr", addr, exp3[k]);
    end
    @(posedge clk); #1 en = 1'b0;

    // 4: frame_start with words queued and a read in flight
    en = 1'b1;
    pulse_fs();
    repeat (6) @(posedge clk);
    #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    @(negedge clk);
    chk("t4_addr_restart", addr, 0);
    chk("t4_rd_restart", rd, 1);
    wait_rts("t4_rts", n);
    stream("t4_8_pixels", 8);

    // 5: underflow from reset with fetching disabled
    en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rtr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_underflow_set", uf, 1);
    chk("t5_pix_zero", pix, 0);
`ifdef PIXEL_FETCH_STATS_EN
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("t5_ucnt_10", ucnt, 10);
`endif
    @(posedge clk); #1 rtr = 1'b0; fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    @(negedge clk);
    chk("t5_underflow_clear", uf, 0);
`ifdef PIXEL_FETCH_STATS_EN
    chk("t5_ucnt_clear", ucnt, 0);
`endif

    // 6: asynchronous reset mid-stream, then restart
    en = 1'b1;
    pulse_fs();
    wait_rts("t6_rts", n);
    @(posedge clk); #1 rtr = 1'b1;
    p0 = pops;
    n  = 0;
    while ((pops - p0) < 37 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_37", (pops - p0) >= 37, 1);
    chk("t6_no_underflow", uf, 0);
    @(posedge clk); #1 rst = 1'b1; rtr = 1'b0;
    #1 chk("t6_async_reset", {addr, rd, pix, rts, uf}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    pulse_fs();
    wait_rts("t6_restart_rts", n);
    stream("t6_restart_pixels", 12);
    chk("t6_end_underflow", uf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
